// File: rtl/sigmoid_arbiter_if.sv
// sigmoid_arbiter_if
//   Requester-side bundle for sigmoid_arbiter: two sample request channels
//   (valid/ready/x) and two response channels (valid/ready/y).
//   master : the requesters (drive samples, consume responses)
//   slave  : the arbiter    (accepts samples, presents responses)
interface sigmoid_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_x;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_x;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [15:0] rsp0_y;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp1_y;

  modport master (
    output req0_valid, req0_x, req1_valid, req1_x, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_y, rsp1_valid, rsp1_y
  );

  modport slave (
    input  req0_valid, req0_x, req1_valid, req1_x, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp0_y, rsp1_valid, rsp1_y
  );
endinterface

// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter
//   Shares one pipelined sigmoid unit between two requesters. At most one
//   sample is issued per cycle, chosen round-robin among requesters that have
//   response space left. A tag pipeline mirrors the sigmoid latency so every
//   result is routed into the response FIFO of the requester that issued it.
//   Response space is reserved at issue, so a FIFO never overflows.
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req             requester bundle (sigmoid_arbiter_if.slave)
//   sig_in_valid    issue strobe to the sigmoid unit
//   sig_x           issued sample (0 when idle)
//   sig_out_valid   result strobe from the sigmoid unit
//   sig_y           result from the sigmoid unit
//   busy            a sample is in flight or a response FIFO holds data
//   err             sticky: tag/valid mismatch or dropped push
module sigmoid_arbiter #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sigmoid_arbiter_if.slave  req,
  output logic              sig_in_valid,
  output logic [7:0]        sig_x,
  input  logic              sig_out_valid,
  input  logic [15:0]       sig_y,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

  logic [CW-1:0] count_r  [2];
  logic [AW-1:0] wr_ptr_r [2];
  logic [AW-1:0] rd_ptr_r [2];
  logic [15:0]   mem_r    [2][DEPTH];
  logic          tag_v_r  [LAT];
  logic          tag_id_r [LAT];
  logic          lg_r;
  logic          err_r;

  logic [CW-1:0] inflight_s [2];
  logic [1:0]    eligible_s;
  logic [1:0]    grant_s;
  logic [1:0]    push_s;
  logic [1:0]    full_s;
  logic [1:0]    push_ok_s;
  logic [1:0]    pop_s;
  logic          mismatch_s;

  // Count in-flight samples per requester from the tag pipeline.
  always_comb begin
    inflight_s[0] = '0;
    inflight_s[1] = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_s[0] = inflight_s[0] + {{(CW-1){1'b0}}, tag_v_r[i] & ~tag_id_r[i]};
      inflight_s[1] = inflight_s[1] + {{(CW-1){1'b0}}, tag_v_r[i] &  tag_id_r[i]};
    end
  end

  // Eligibility (credit left) and round-robin grant; nothing is granted in reset.
  always_comb begin
    eligible_s[0] = req.req0_valid && ((count_r[0] + inflight_s[0]) < CW'(DEPTH));
    eligible_s[1] = req.req1_valid && ((count_r[1] + inflight_s[1]) < CW'(DEPTH));
    grant_s = 2'b00;
    if (rst) begin
      grant_s = 2'b00;
    end else if (eligible_s == 2'b11) begin
      // lg_r names the port granted last; a tie goes to the other port.
      grant_s = lg_r ? 2'b01 : 2'b10;
    end else begin
      grant_s = eligible_s;
    end
  end

  // Result routing at the last tag stage plus FIFO push/pop qualification.
  always_comb begin
    push_s[0]  = tag_v_r[LAT-1] && sig_out_valid && !tag_id_r[LAT-1];
    push_s[1]  = tag_v_r[LAT-1] && sig_out_valid &&  tag_id_r[LAT-1];
    full_s[0]  = (count_r[0] == CW'(DEPTH));
    full_s[1]  = (count_r[1] == CW'(DEPTH));
    push_ok_s  = push_s & ~full_s;
    pop_s[0]   = (count_r[0] != '0) && req.rsp0_ready;
    pop_s[1]   = (count_r[1] != '0) && req.rsp1_ready;
    mismatch_s = (tag_v_r[LAT-1] != sig_out_valid);
  end

  assign req.req0_ready = grant_s[0];
  assign req.req1_ready = grant_s[1];
  assign sig_in_valid   = |grant_s;
  assign sig_x          = grant_s[0] ? req.req0_x : (grant_s[1] ? req.req1_x : 8'h00);
  assign req.rsp0_valid = (count_r[0] != '0);
  assign req.rsp1_valid = (count_r[1] != '0);
  assign req.rsp0_y     = (count_r[0] != '0) ? mem_r[0][rd_ptr_r[0]] : 16'h0000;
  assign req.rsp1_y     = (count_r[1] != '0) ? mem_r[1][rd_ptr_r[1]] : 16'h0000;
  assign busy           = (count_r[0] != '0) || (count_r[1] != '0) ||
                          (inflight_s[0] != '0) || (inflight_s[1] != '0);
  assign err            = err_r;

  // Tag pipeline: stage 0 captures the issue, later stages follow the sigmoid depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_v_r[i]  <= 1'b0;
        tag_id_r[i] <= 1'b0;
      end
    end else begin
      tag_v_r[0]  <= |grant_s;
      tag_id_r[0] <= grant_s[1];
      for (int i = 1; i < LAT; i++) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // FIFO bookkeeping; a push into a full FIFO is dropped (flagged via err_r).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        count_r[k]  <= '0;
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        count_r[k]  <= count_r[k] + {{(CW-1){1'b0}}, push_ok_s[k]}
                                  - {{(CW-1){1'b0}}, pop_s[k]};
        wr_ptr_r[k] <= wr_ptr_r[k] + {{(AW-1){1'b0}}, push_ok_s[k]};
        rd_ptr_r[k] <= rd_ptr_r[k] + {{(AW-1){1'b0}}, pop_s[k]};
      end
    end
  end

  // Response storage; unreset, the head is masked to 0 while a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && push_ok_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= sig_y;
      end
    end
  end

  // Last-grant pointer and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lg_r  <= 1'b1;
      err_r <= 1'b0;
    end else begin
      lg_r  <= (|grant_s) ? grant_s[1] : lg_r;
      err_r <= err_r | mismatch_s | (|(push_s & full_s));
    end
  end
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// tb_sigmoid_arbiter
//   Drives sigmoid_arbiter with directed and random traffic, emulates the
//   sigmoid unit (piecewise-linear sigmoid, LAT register stages), and checks
//   every cycle against a queue-based model of the arbiter.
module tb_sigmoid_arbiter;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in_valid;
  logic [7:0]  sig_x;
  logic        sig_out_valid;
  logic [15:0] sig_y;
  logic        busy;
  logic        err;
  logic        inject;
  int          n_checks = 0;
  int          n_fail   = 0;

  sigmoid_arbiter_if rif ();

  sigmoid_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(rif),
    .sig_in_valid(sig_in_valid), .sig_x(sig_x),
    .sig_out_valid(sig_out_valid), .sig_y(sig_y),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Piecewise-linear sigmoid: x signed Q2.5, y scaled by 32768.
  function automatic logic [15:0] plan(input logic [7:0] x);
    int v, a, y;
    v = int'($signed(x));
    a = (v < 0) ? -v : v;
    if (a < 32)      y = 256 * a + 16384;
    else if (a < 76) y = 128 * a + 20480;
    else             y = 32 * a + 27648;
    if (v < 0) y = 32768 - y;
    return y[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  // Sigmoid unit stand-in; its reset follows rst like the integrated unit.
  logic        su_v [LAT];
  logic [15:0] su_y [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin su_v[i] <= 1'b0; su_y[i] <= 16'h0000; end
    end else begin
      su_v[0] <= sig_in_valid;
      su_y[0] <= plan(sig_x);
      for (int i = 1; i < LAT; i++) begin su_v[i] <= su_v[i-1]; su_y[i] <= su_y[i-1]; end
    end
  end
  assign sig_out_valid = su_v[LAT-1] | inject;
  assign sig_y         = su_y[LAT-1];

  // Reference model state: pending results with their push cycle, response queues.
  typedef struct { int id; int y; int due; } pend_t;
  pend_t pend[$];
  int    q0[$];
  int    q1[$];
  int    m_lg  = 1;
  bit    m_err = 1'b0;
  int    cyc   = 0;

  // Model: predict this cycle's outputs, compare, then advance one cycle.
  always @(negedge clk) begin
    int    inf0, inf1, g, ex_x;
    bit    e0, e1, due_now;
    pend_t p;
    inf0 = 0; inf1 = 0;
    foreach (pend[i]) if (pend[i].id == 0) inf0++; else inf1++;
    e0 = rif.req0_valid && (DEPTH - q0.size() - inf0 > 0);
    e1 = rif.req1_valid && (DEPTH - q1.size() - inf1 > 0);
    if (rst)            g = -1;
    else if (e0 && e1)  g = (m_lg == 0) ? 1 : 0;
    else if (e0)        g = 0;
    else if (e1)        g = 1;
    else                g = -1;
    ex_x = (g == 0) ? int'(rif.req0_x) : ((g == 1) ? int'(rif.req1_x) : 0);
    check("m_req0_ready", rif.req0_ready, g == 0);
    check("m_req1_ready", rif.req1_ready, g == 1);
    check("m_sig_in_valid", sig_in_valid, g >= 0);
    check("m_sig_x", sig_x, ex_x);
    if (!rst) begin
      check("m_rsp0_valid", rif.rsp0_valid, q0.size() != 0);
      check("m_rsp1_valid", rif.rsp1_valid, q1.size() != 0);
      check("m_rsp0_y", rif.rsp0_y, (q0.size() != 0) ? q0[0] : 0);
      check("m_rsp1_y", rif.rsp1_y, (q1.size() != 0) ? q1[0] : 0);
      check("m_busy", busy, (pend.size() != 0) || (q0.size() != 0) || (q1.size() != 0));
      check("m_err", err, m_err);
    end
    if (rst) begin
      pend.delete(); q0.delete(); q1.delete();
      m_lg = 1; m_err = 1'b0;
    end else begin
      if (q0.size() != 0 && rif.rsp0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && rif.rsp1_ready) void'(q1.pop_front());
      due_now = 1'b0;
      while (pend.size() != 0 && pend[0].due == cyc) begin
        due_now = 1'b1;
        if (pend[0].id == 0) q0.push_back(pend[0].y); else q1.push_back(pend[0].y);
        void'(pend.pop_front());
      end
      if (inject && !due_now) m_err = 1'b1;
      if (g >= 0) begin
        p.id  = g;
        p.y   = int'(plan(8'(ex_x)));
        p.due = cyc + LAT;
        pend.push_back(p);
        m_lg = g;
      end
    end
    cyc++;
  end

  // Collects port-0 pops for the in-order check.
  bit collect = 1'b0;
  int got[$];
  always @(negedge clk) begin
    if (collect && rif.rsp0_valid && rif.rsp0_ready) got.push_back(int'(rif.rsp0_y));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
    rif.req0_x = 8'h00;    rif.req1_x = 8'h00;
    rif.rsp0_ready = 1'b0; rif.rsp1_ready = 1'b0;
  endtask

  // One reset cycle; returns at the start of the first post-reset cycle.
  task automatic do_reset();
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic wait_rsp(input int port, input logic [15:0] exp, input string name);
    int n = 0;
    bit found = 1'b0;
    while (!found && n < 10) begin
      @(negedge clk);
      if ((port == 0) ? rif.rsp0_valid : rif.rsp1_valid) found = 1'b1;
      else begin tick(); n++; end
    end
    if (!found) fail_now(name);
    else check(name, (port == 0) ? rif.rsp0_y : rif.rsp1_y, exp);
  endtask

  initial begin
    int acc, k, n;
    logic [7:0] xs [10];
    rst = 1'b1; inject = 1'b0; idle();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp0_valid", rif.rsp0_valid, 1'b0);
    check("reset_rsp1_valid", rif.rsp1_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_rsp0_y", rif.rsp0_y, 16'h0000);

    // Single sample through port 0.
    tick(); rif.req0_valid = 1'b1; rif.req0_x = 8'h00;
    @(negedge clk);
    check("t1_ready", rif.req0_ready, 1'b1);
    check("t1_sig_in_valid", sig_in_valid, 1'b1);
    tick(); rif.req0_valid = 1'b0;
    @(negedge clk);
    check("t1_no_bypass", rif.rsp0_valid, 1'b0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid", rif.rsp0_valid, 1'b1);
    check("t1_rsp_y", rif.rsp0_y, 16'h4000);
    tick(); rif.rsp0_ready = 1'b1;
    tick(); rif.rsp0_ready = 1'b0;

    // Contention: alternating grants, port 0 first after reset.
    do_reset();
    rif.rsp0_ready = 1'b1; rif.rsp1_ready = 1'b1;
    rif.req0_valid = 1'b1; rif.req1_valid = 1'b1;
    rif.req0_x = 8'h40;    rif.req1_x = 8'hC0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      @(negedge clk);
      check("t2_grant0", rif.req0_ready, (i % 2) == 0);
      check("t2_grant1", rif.req1_ready, (i % 2) == 1);
    end
    tick(); rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
    wait_rsp(0, 16'h7000, "t2_rsp0_y");
    wait_rsp(1, 16'h1000, "t2_rsp1_y");
    tick(); idle(); repeat (6) tick();

    // Backpressure on port 0: credits run out after DEPTH accepts.
    do_reset();
    rif.req0_valid = 1'b1; rif.req0_x = 8'h20;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      @(negedge clk);
      acc += int'(rif.req0_ready);
    end
    check("t3_accepts", acc, DEPTH);
    check("t3_ready_low", rif.req0_ready, 1'b0);
    tick(); rif.rsp0_ready = 1'b1;
    @(negedge clk);
    check("t3_pop_valid", rif.rsp0_valid, 1'b1);
    check("t3_no_accept_in_pop", rif.req0_ready, 1'b0);
    tick(); rif.rsp0_ready = 1'b0;
    @(negedge clk);
    check("t3_reaccept", rif.req0_ready, 1'b1);
    tick();
    @(negedge clk);
    check("t3_full_again", rif.req0_ready, 1'b0);
    tick(); idle(); rif.rsp0_ready = 1'b1; repeat (8) tick();

    // Wrap: ten samples through port 0, all returned in order.
    for (int i = 0; i < 10; i++) xs[i] = 8'($urandom);
    got.delete(); collect = 1'b1; rif.rsp0_ready = 1'b1;
    k = 0; n = 0;
    while (k < 10 && n < 60) begin
      tick(); rif.req0_valid = 1'b1; rif.req0_x = xs[k];
      @(negedge clk);
      if (rif.req0_ready) k++;
      n++;
    end
    if (k < 10) fail_now("t4_accept_budget");
    tick(); rif.req0_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t4_busy_last", busy, 1'b1);
    tick();
    @(negedge clk);
    check("t4_busy_drop", busy, 1'b0);
    collect = 1'b0;
    check("t4_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      check($sformatf("t4_out%0d", i), got[i], plan(xs[i]));

    // Reset with three samples pending.
    rif.rsp0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); rif.req0_valid = 1'b1; rif.req0_x = 8'(8'h10 + i);
    end
    tick(); rst = 1'b1; rif.req1_valid = 1'b1;
    @(negedge clk);
    check("t5_ready0_in_rst", rif.req0_ready, 1'b0);
    check("t5_ready1_in_rst", rif.req1_ready, 1'b0);
    check("t5_issue_in_rst", sig_in_valid, 1'b0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t5_rsp0_valid", rif.rsp0_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_err", err, 1'b0);
    check("t5_first_tie", rif.req0_ready, 1'b1);
    tick();
    @(negedge clk);
    check("t5_second_tie", rif.req1_ready, 1'b1);
    tick(); idle(); rif.rsp0_ready = 1'b1; rif.rsp1_ready = 1'b1; repeat (6) tick();

    // Fault: spurious sigmoid result with an empty pipeline.
    tick(); inject = 1'b1;
    @(negedge clk);
    check("t6_err_before", err, 1'b0);
    tick(); inject = 1'b0;
    @(negedge clk);
    check("t6_err_set", err, 1'b1);
    repeat (5) tick();
    @(negedge clk);
    check("t6_err_held", err, 1'b1);
    do_reset();
    @(negedge clk);
    check("t6_err_cleared", err, 1'b0);

    // Random traffic with occasional resets, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst            = ($urandom_range(0, 199) == 0);
      rif.req0_valid = ($urandom_range(0, 99) < 60);
      rif.req1_valid = ($urandom_range(0, 99) < 60);
      rif.req0_x     = 8'($urandom);
      rif.req1_x     = 8'($urandom);
      rif.rsp0_ready = ($urandom_range(0, 99) < 50);
      rif.rsp1_ready = ($urandom_range(0, 99) < 50);
    end
    tick(); rst = 1'b0; idle(); rif.rsp0_ready = 1'b1; rif.rsp1_ready = 1'b1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
